// File: rtl/riscv_pkg.sv
// Shared types and defaults for the core-side memory arbiter.
//   SRC_IF / SRC_DM : requester id carried alongside each in-flight read
//   tag_t           : {valid, src} tag riding the read-latency pipeline
//   *_DEF           : default read latency and IF starvation bound
package riscv_pkg;

  localparam logic SRC_IF = 1'b0;
  localparam logic SRC_DM = 1'b1;

  localparam int RD_LAT_DEF     = 1;
  localparam int STARVE_MAX_DEF = 4;

  typedef struct packed {
    logic valid;
    logic src;
  } tag_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// DEPTH-deep shift register of read tags, matching the memory read latency.
//   clk     : clock
//   rst     : synchronous clear (drops every in-flight tag)
//   tag_in  : tag for the access issued this cycle
//   tag_out : tag whose read data is on the memory port this cycle
module rd_tag_pipe
  import riscv_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t [DEPTH-1:0] pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe <= '0;
    end else begin
      pipe[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tag_out = pipe[DEPTH-1];

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous SRAM between instruction fetch (IF)
// and data memory (DM). DM wins conflicts unless IF has been denied
// STARVE_MAX times in a row. Read data is routed back by a tag pipeline.
//   clk, rst              : clock, synchronous active-high reset
//   if_req_i/if_addr_i    : IF read request       -> if_gnt_o
//   if_rvalid_o/rdata_o   : IF read return
//   dm_req_i/we/addr/wdata: DM read/write request -> dm_gnt_o
//   dm_rvalid_o/rdata_o   : DM read return
//   mem_*                 : SRAM port (rdata valid RD_LAT cycles after issue)
//   stall_o               : some request was denied this cycle
//   if_wait_cnt_o         : running count of IF denial cycles
module mem_arbiter
  import riscv_pkg::*;
#(
  parameter int RD_LAT     = RD_LAT_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int AW         = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic          if_gnt_o,
  output logic          if_rvalid_o,
  output logic [31:0]   if_rdata_o,
  input  logic          dm_req_i,
  input  logic          dm_we_i,
  input  logic [AW-1:0] dm_addr_i,
  input  logic [31:0]   dm_wdata_i,
  output logic          dm_gnt_o,
  output logic          dm_rvalid_o,
  output logic [31:0]   dm_rdata_o,
  output logic          mem_ce_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  input  logic [31:0]   mem_rdata_i,
  output logic          stall_o,
  output logic [31:0]   if_wait_cnt_o
);

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  logic [3:0]  starve_cnt;
  logic [31:0] wait_cnt;
  logic        if_wins, if_den;
  tag_t        tag_in, tag_out;

  // IF takes the port when alone, or when it has starved long enough.
  // Everything is forced quiet while rst is high.
  assign if_wins  = if_req_i & (~dm_req_i | (starve_cnt == SMAX));
  assign if_gnt_o = ~rst & if_wins;
  assign dm_gnt_o = ~rst & dm_req_i & ~if_wins;

  assign if_den  = ~rst & if_req_i & ~if_gnt_o;
  assign stall_o = if_den | (~rst & dm_req_i & ~dm_gnt_o);

  assign mem_ce_o    = if_gnt_o | dm_gnt_o;
  assign mem_we_o    = dm_gnt_o & dm_we_i;
  assign mem_addr_o  = dm_gnt_o ? dm_addr_i  : (if_gnt_o ? if_addr_i : '0);
  assign mem_wdata_o = dm_gnt_o ? dm_wdata_i : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      wait_cnt   <= '0;
    end else begin
      if (if_den) begin
        starve_cnt <= (starve_cnt == 4'hF) ? starve_cnt : starve_cnt + 4'd1;
        wait_cnt   <= wait_cnt + 32'd1;
      end else begin
        starve_cnt <= '0;
      end
    end
  end

  assign if_wait_cnt_o = rst ? '0 : wait_cnt;

  // Only reads get a tag; writes leave a bubble in the return pipeline.
  always_comb begin
    tag_in       = '0;
    tag_in.valid = mem_ce_o & ~mem_we_o;
    tag_in.src   = dm_gnt_o ? SRC_DM : SRC_IF;
  end

  rd_tag_pipe #(.DEPTH(RD_LAT)) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Gating with rst also kills a return landing in the first reset cycle.
  assign if_rvalid_o = ~rst & tag_out.valid & (tag_out.src == SRC_IF);
  assign dm_rvalid_o = ~rst & tag_out.valid & (tag_out.src == SRC_DM);
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
  assign dm_rdata_o  = dm_rvalid_o ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // ---------------- DUT A: RD_LAT=2, STARVE_MAX=4 ----------------
  logic        a_if_req, a_dm_req, a_dm_we;
  logic [31:0] a_if_addr, a_dm_addr, a_dm_wdata;
  logic        a_if_gnt, a_if_rv, a_dm_gnt, a_dm_rv, a_ce, a_we, a_stall;
  logic [31:0] a_if_rd, a_dm_rd, a_maddr, a_mwd, a_mrd, a_wcnt;

  mem_arbiter #(.RD_LAT(2), .STARVE_MAX(4), .AW(32)) u_dut_a (
    .clk(clk), .rst(rst),
    .if_req_i(a_if_req), .if_addr_i(a_if_addr), .if_gnt_o(a_if_gnt),
    .if_rvalid_o(a_if_rv), .if_rdata_o(a_if_rd),
    .dm_req_i(a_dm_req), .dm_we_i(a_dm_we), .dm_addr_i(a_dm_addr),
    .dm_wdata_i(a_dm_wdata), .dm_gnt_o(a_dm_gnt), .dm_rvalid_o(a_dm_rv),
    .dm_rdata_o(a_dm_rd), .mem_ce_o(a_ce), .mem_we_o(a_we),
    .mem_addr_o(a_maddr), .mem_wdata_o(a_mwd), .mem_rdata_i(a_mrd),
    .stall_o(a_stall), .if_wait_cnt_o(a_wcnt)
  );

  logic [31:0] mem_a [256];
  logic [31:0] dly_a [2];
  always @(posedge clk) begin
    if (a_ce && a_we) mem_a[a_maddr[9:2]] <= a_mwd;
    dly_a[0] <= (a_ce && !a_we) ? mem_a[a_maddr[9:2]] : 32'h0;
    dly_a[1] <= dly_a[0];
  end
  assign a_mrd = dly_a[1];

  // ---------------- DUT B: RD_LAT=3 (throughput) ----------------
  logic        b_dm_req;
  logic [31:0] b_dm_addr;
  logic        b_if_gnt, b_if_rv, b_dm_gnt, b_dm_rv, b_ce, b_we, b_stall;
  logic [31:0] b_if_rd, b_dm_rd, b_maddr, b_mwd, b_mrd, b_wcnt;

  mem_arbiter #(.RD_LAT(3), .STARVE_MAX(4), .AW(32)) u_dut_b (
    .clk(clk), .rst(rst),
    .if_req_i(1'b0), .if_addr_i(32'h0), .if_gnt_o(b_if_gnt),
    .if_rvalid_o(b_if_rv), .if_rdata_o(b_if_rd),
    .dm_req_i(b_dm_req), .dm_we_i(1'b0), .dm_addr_i(b_dm_addr),
    .dm_wdata_i(32'h0), .dm_gnt_o(b_dm_gnt), .dm_rvalid_o(b_dm_rv),
    .dm_rdata_o(b_dm_rd), .mem_ce_o(b_ce), .mem_we_o(b_we),
    .mem_addr_o(b_maddr), .mem_wdata_o(b_mwd), .mem_rdata_i(b_mrd),
    .stall_o(b_stall), .if_wait_cnt_o(b_wcnt)
  );

  logic [31:0] mem_b [256];
  logic [31:0] dly_b [3];
  always @(posedge clk) begin
    if (b_ce && b_we) mem_b[b_maddr[9:2]] <= b_mwd;
    dly_b[0] <= (b_ce && !b_we) ? mem_b[b_maddr[9:2]] : 32'h0;
    dly_b[1] <= dly_b[0];
    dly_b[2] <= dly_b[1];
  end
  assign b_mrd = dly_b[2];

  // ---------------- helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_if_req = 0; a_if_addr = 0;
    a_dm_req = 0; a_dm_we = 0; a_dm_addr = 0; a_dm_wdata = 0;
    b_dm_req = 0; b_dm_addr = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    cyc(); cyc();
    rst = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 32'h0;
      mem_b[i] = 32'hC0DE0000 | 32'(i);
    end
    mem_a[8'h00] = 32'hA0A0A0A0;
    mem_a[8'h10] = 32'hDEADBEEF;  // 0x40
    mem_a[8'h40] = 32'h11111111;  // 0x100
    mem_a[8'h80] = 32'h22222222;  // 0x200
    for (int i = 0; i < 3; i++) begin dly_a[i%2] = 0; dly_b[i] = 0; end

    // Reset state, with requests asserted to show they are suppressed
    idle();
    rst = 1;
    cyc();
    a_if_req = 1; a_dm_req = 1; a_dm_we = 1; a_dm_addr = 32'h300;
    @(negedge clk);
    chk("rst_if_gnt", 32'(a_if_gnt), 0);
    chk("rst_dm_gnt", 32'(a_dm_gnt), 0);
    chk("rst_ce",     32'(a_ce), 0);
    chk("rst_we",     32'(a_we), 0);
    chk("rst_addr",   a_maddr, 0);
    chk("rst_stall",  32'(a_stall), 0);
    chk("rst_wcnt",   a_wcnt, 0);
    chk("rst_rvalid", 32'({a_if_rv, a_dm_rv}), 0);
    do_reset();

    // Single IF read, RD_LAT=2
    a_if_req = 1; a_if_addr = 32'h40;
    @(negedge clk);
    chk("ifrd_gnt",   32'(a_if_gnt), 1);
    chk("ifrd_addr",  a_maddr, 32'h40);
    chk("ifrd_we",    32'(a_we), 0);
    chk("ifrd_stall", 32'(a_stall), 0);
    cyc(); idle();
    @(negedge clk);
    chk("ifrd_rv_c1", 32'(a_if_rv), 0);
    chk("idle_addr",  a_maddr, 0);
    chk("idle_ce",    32'(a_ce), 0);
    cyc();
    @(negedge clk);
    chk("ifrd_rv_c2", 32'(a_if_rv), 1);
    chk("ifrd_data",  a_if_rd, 32'hDEADBEEF);
    chk("ifrd_dmrd0", a_dm_rd, 0);
    chk("ifrd_stall2", 32'(a_stall), 0);
    cyc();
    @(negedge clk);
    chk("ifrd_rv_c3", 32'(a_if_rv), 0);

    // Conflict: DM wins, IF follows
    do_reset();
    a_if_req = 1; a_if_addr = 32'h0; a_dm_req = 1; a_dm_addr = 32'h200;
    @(negedge clk);
    chk("cf_dm_gnt", 32'(a_dm_gnt), 1);
    chk("cf_if_gnt", 32'(a_if_gnt), 0);
    chk("cf_stall",  32'(a_stall), 1);
    chk("cf_addr",   a_maddr, 32'h200);
    cyc(); a_dm_req = 0; a_dm_addr = 0;
    @(negedge clk);
    chk("cf_if_gnt1", 32'(a_if_gnt), 1);
    chk("cf_addr1",   a_maddr, 32'h0);
    chk("cf_stall1",  32'(a_stall), 0);
    cyc(); idle();
    @(negedge clk);
    chk("cf_dm_rv",   32'(a_dm_rv), 1);
    chk("cf_dm_data", a_dm_rd, 32'h22222222);
    chk("cf_if_rv2",  32'(a_if_rv), 0);
    cyc();
    @(negedge clk);
    chk("cf_if_rv",   32'(a_if_rv), 1);
    chk("cf_if_data", a_if_rd, 32'hA0A0A0A0);
    chk("cf_dm_rv3",  32'(a_dm_rv), 0);
    chk("cf_wcnt",    a_wcnt, 1);

    // Starvation: both request continuously, IF wins every 5th cycle
    do_reset();
    a_if_req = 1; a_if_addr = 32'h0; a_dm_req = 1; a_dm_addr = 32'h200;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("sv_if_gnt%0d", k), 32'(a_if_gnt), 32'((k % 5) == 4));
      chk($sformatf("sv_dm_gnt%0d", k), 32'(a_dm_gnt), 32'((k % 5) != 4));
      if (k == 5) chk("sv_wcnt5", a_wcnt, 4);
      if (k == 9) chk("sv_wcnt9", a_wcnt, 8);
      cyc();
    end

    // DM write then IF read-back
    do_reset();
    a_dm_req = 1; a_dm_we = 1; a_dm_addr = 32'h300; a_dm_wdata = 32'h12345678;
    @(negedge clk);
    chk("wr_gnt",   32'(a_dm_gnt), 1);
    chk("wr_we",    32'(a_we), 1);
    chk("wr_wdata", a_mwd, 32'h12345678);
    chk("wr_addr",  a_maddr, 32'h300);
    cyc(); idle(); a_if_req = 1; a_if_addr = 32'h300;
    @(negedge clk);
    chk("wr_if_gnt", 32'(a_if_gnt), 1);
    chk("wr_if_we",  32'(a_we), 0);
    chk("wr_if_wd",  a_mwd, 0);
    cyc(); idle();
    @(negedge clk);
    chk("wr_no_rv",  32'(a_dm_rv), 0);
    cyc();
    @(negedge clk);
    chk("wr_if_rv",   32'(a_if_rv), 1);
    chk("wr_if_data", a_if_rd, 32'h12345678);
    chk("wr_no_rv3",  32'(a_dm_rv), 0);

    // Reset mid-read: read granted, rst next cycle -> never returns
    do_reset();
    a_if_req = 1; a_if_addr = 32'h100;
    @(negedge clk);
    chk("rm_gnt", 32'(a_if_gnt), 1);
    cyc(); rst = 1; a_dm_req = 1;
    @(negedge clk);
    chk("rm_if_gnt1", 32'(a_if_gnt), 0);
    chk("rm_ce1",     32'(a_ce), 0);
    chk("rm_stall1",  32'(a_stall), 0);
    chk("rm_rv1",     32'(a_if_rv), 0);
    cyc();
    @(negedge clk);
    chk("rm_rv2",   32'(a_if_rv), 0);
    chk("rm_rd2",   a_if_rd, 0);
    cyc(); rst = 0; idle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rm_rv_post%0d", k), 32'(a_if_rv), 0);
      cyc();
    end

    // Throughput on DUT B: 8 back-to-back DM reads, RD_LAT=3
    do_reset();
    for (int k = 0; k < 12; k++) begin
      b_dm_req  = (k < 8);
      b_dm_addr = (k < 8) ? 32'(4 * k) : 32'h0;
      @(negedge clk);
      chk($sformatf("tp_gnt%0d", k), 32'(b_dm_gnt), 32'(k < 8));
      chk($sformatf("tp_rv%0d", k), 32'(b_dm_rv), 32'((k >= 3) && (k <= 10)));
      if ((k >= 3) && (k <= 10))
        chk($sformatf("tp_data%0d", k), b_dm_rd, 32'hC0DE0000 | 32'(k - 3));
      cyc();
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
